// File: rtl/tinyqv_fetch_pkg.sv
// Shared types and helpers for the TinyQV instruction prefetch path.
// Halfword width and RV32/RVC length decode live here so fetch-side blocks agree.
package tinyqv_fetch_pkg;

    localparam int HW_WIDTH = 16;

    // Low two bits 2'b11 mark a 32-bit instruction; anything else is compressed.
    function automatic logic [1:0] instr_len_of(input logic [HW_WIDTH-1:0] halfword);
        return (halfword[1:0] == 2'b11) ? 2'd2 : 2'd1;
    endfunction

    // Occupancy needs one bit more than the index so that 0..DEPTH all fit.
    function automatic int count_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/tinyqv_prefetch_buffer.sv
// Instruction prefetch queue: buffers QSPI halfwords and presents one complete
// RV32/RVC instruction at the head together with its PC.
module tinyqv_prefetch_buffer
    import tinyqv_fetch_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int ADDR_BITS  = 23
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  branch,
    input  logic [ADDR_BITS-1:0]  branch_addr,
    input  logic                  instr_fetch_started,
    input  logic                  instr_fetch_stopped,
    input  logic [15:0]           instr_data_in,
    input  logic                  instr_ready,
    input  logic                  instr_consume,
    output logic [ADDR_BITS-1:0]  instr_addr,
    output logic                  instr_fetch_restart,
    output logic                  instr_fetch_stall,
    output logic [31:0]           instr,
    output logic [1:0]            instr_len,
    output logic                  instr_valid,
    output logic [ADDR_BITS-1:0]  instr_pc,
    output logic [DEPTH_LOG2:0]   avail
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = count_width(DEPTH_LOG2);

    logic [HW_WIDTH-1:0]   mem [DEPTH];

    logic [CW-1:0]         rd_reg, rd_next;
    logic [CW-1:0]         wr_reg, wr_next;
    logic [CW-1:0]         count, count_next;
    logic [ADDR_BITS-1:0]  pc_reg, pc_next;
    logic                  fetch_running_reg, fetch_running_next;

    logic [DEPTH_LOG2-1:0] rd_idx, rd_idx_p1, wr_idx;
    logic [HW_WIDTH-1:0]   head_lo, head_hi;
    logic                  wr_en, pop;

    assign rd_idx    = rd_reg[DEPTH_LOG2-1:0];
    // Index arithmetic wraps at DEPTH, so a 32-bit instruction at the last
    // entry takes its upper half from entry 0.
    assign rd_idx_p1 = rd_idx + DEPTH_LOG2'(1);
    assign wr_idx    = wr_reg[DEPTH_LOG2-1:0];
    assign count     = wr_reg - rd_reg;

    assign head_lo   = mem[rd_idx];
    assign head_hi   = mem[rd_idx_p1];

    assign instr_len   = instr_len_of(head_lo);
    assign instr_valid = ((count != '0) && (instr_len == 2'd1)) || (count >= CW'(2));
    assign instr       = (instr_len == 2'd2) ? {head_hi, head_lo} : {16'h0000, head_lo};

    assign wr_en = instr_ready && fetch_running_reg && !branch;
    assign pop   = instr_consume && instr_valid && !branch;

    always_comb begin
        rd_next            = rd_reg;
        wr_next            = wr_reg;
        pc_next            = pc_reg;
        fetch_running_next = fetch_running_reg;
        if (branch) begin
            rd_next            = '0;
            wr_next            = '0;
            pc_next            = branch_addr;
            fetch_running_next = 1'b0;
        end else begin
            if (wr_en) begin
                wr_next = wr_reg + CW'(1);
            end
            if (pop) begin
                rd_next = rd_reg + CW'(instr_len);
                pc_next = pc_reg + ADDR_BITS'(instr_len);
            end
            if (instr_fetch_started) begin
                fetch_running_next = 1'b1;
            end else if (instr_fetch_stopped) begin
                fetch_running_next = 1'b0;
            end
        end
    end

    assign count_next = wr_next - rd_next;

    // Raised a cycle early so the controller has time to stop streaming.
    assign instr_fetch_stall   = (count_next == CW'(DEPTH));
    assign instr_fetch_restart = !fetch_running_reg && !branch;
    assign instr_addr          = pc_reg + ADDR_BITS'(count);
    assign instr_pc            = pc_reg;
    assign avail               = count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_reg            <= '0;
            wr_reg            <= '0;
            pc_reg            <= '0;
            fetch_running_reg <= 1'b0;
        end else begin
            rd_reg            <= rd_next;
            wr_reg            <= wr_next;
            pc_reg            <= pc_next;
            fetch_running_reg <= fetch_running_next;
        end
    end

    // Storage carries no reset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= instr_data_in;
        end
    end

endmodule

// File: tb/tb_tinyqv_prefetch_buffer.sv
// Self-checking bench for tinyqv_prefetch_buffer: directed table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_tinyqv_prefetch_buffer;

    localparam int DL    = 2;
    localparam int AB    = 23;
    localparam int DEPTH = 1 << DL;
    localparam int unsigned AMASK = (32'd1 << AB) - 1;

    logic          clk;
    logic          rstn;
    logic          branch;
    logic [AB-1:0] branch_addr;
    logic          instr_fetch_started;
    logic          instr_fetch_stopped;
    logic [15:0]   instr_data_in;
    logic          instr_ready;
    logic          instr_consume;
    logic [AB-1:0] instr_addr;
    logic          instr_fetch_restart;
    logic          instr_fetch_stall;
    logic [31:0]   instr;
    logic [1:0]    instr_len;
    logic          instr_valid;
    logic [AB-1:0] instr_pc;
    logic [DL:0]   avail;

    tinyqv_prefetch_buffer #(.DEPTH_LOG2(DL), .ADDR_BITS(AB)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .branch              (branch),
        .branch_addr         (branch_addr),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data_in       (instr_data_in),
        .instr_ready         (instr_ready),
        .instr_consume       (instr_consume),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr               (instr),
        .instr_len           (instr_len),
        .instr_valid         (instr_valid),
        .instr_pc            (instr_pc),
        .avail               (avail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    // Reference model: the queue holds exactly the halfwords not yet consumed.
    logic [15:0] mq[$];
    int unsigned m_pc;
    bit          m_run;
    int          m_len;
    bit          m_valid, m_wr, m_pop, m_stall, m_restart;
    logic [31:0] m_instr;

    typedef struct {
        logic        st;
        logic        rdy;
        logic [15:0] d;
        logic        cons;
        int          e_avail;
        logic        e_valid;
        logic [1:0]  e_len;
        logic [31:0] e_instr;
        int          e_pc;
        logic        e_stall;
        logic        e_restart;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(logic st, logic rdy, logic [15:0] d, logic cons,
                                int ea, logic ev, logic [1:0] el, logic [31:0] ei,
                                int ep, logic es, logic er);
        vec_t v;
        v.st = st; v.rdy = rdy; v.d = d; v.cons = cons;
        v.e_avail = ea; v.e_valid = ev; v.e_len = el; v.e_instr = ei;
        v.e_pc = ep; v.e_stall = es; v.e_restart = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_eval();
        int n;
        n = mq.size();
        m_len     = (n > 0 && mq[0][1:0] == 2'b11) ? 2 : 1;
        m_valid   = (n >= 1 && m_len == 1) || (n >= 2);
        m_instr   = 32'h0;
        if (m_len == 2 && n >= 2) m_instr = {mq[1], mq[0]};
        else if (n >= 1)          m_instr = {16'h0000, mq[0]};
        m_wr      = instr_ready && m_run && !branch;
        m_pop     = instr_consume && m_valid && !branch;
        m_stall   = !branch && ((n + (m_wr ? 1 : 0) - (m_pop ? m_len : 0)) == DEPTH);
        m_restart = !m_run && !branch;
    endtask

    task automatic m_update();
        if (m_wr) chk("room_for_write", 32'(avail < (DL+1)'(DEPTH)), 32'd1);
        if (branch) begin
            mq.delete();
            m_pc  = 32'(branch_addr);
            m_run = 1'b0;
        end else begin
            if (m_pop) begin
                repeat (m_len) void'(mq.pop_front());
                m_pc = (m_pc + 32'(m_len)) & AMASK;
            end
            if (m_wr) mq.push_back(instr_data_in);
            if (instr_fetch_started)      m_run = 1'b1;
            else if (instr_fetch_stopped) m_run = 1'b0;
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_pc  = 0;
        m_run = 1'b0;
    endtask

    // Drive one cycle's inputs and compare every output with the model.
    task automatic drive_check(input logic br, input logic [AB-1:0] ba, input logic st,
                               input logic sp, input logic rdy, input logic [15:0] d,
                               input logic cons);
        branch = br; branch_addr = ba; instr_fetch_started = st; instr_fetch_stopped = sp;
        instr_ready = rdy; instr_data_in = d; instr_consume = cons;
        #1;
        m_eval();
        chk("avail", 32'(avail), 32'(mq.size()));
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("pc", 32'(instr_pc), m_pc);
        chk("addr", 32'(instr_addr), (m_pc + 32'(mq.size())) & AMASK);
        chk("stall", 32'(instr_fetch_stall), 32'(m_stall));
        chk("restart", 32'(instr_fetch_restart), 32'(m_restart));
        if (m_valid) begin
            chk("len", 32'(instr_len), 32'(m_len));
            chk("instr", instr, m_instr);
        end
        $display("txn %0d br=%0b st=%0b sp=%0b rdy=%0b d=%h cons=%0b avail=%0d valid=%0b instr=%h pc=%h",
                 txn, br, st, sp, rdy, d, cons, avail, instr_valid, instr, instr_pc);
        txn++;
    endtask

    task automatic advance();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic step(input logic br, input logic [AB-1:0] ba, input logic st,
                        input logic sp, input logic rdy, input logic [15:0] d,
                        input logic cons);
        drive_check(br, ba, st, sp, rdy, d, cons);
        advance();
    endtask

    initial begin
        logic [15:0] rd_data;

        rstn = 1'b0; branch = 1'b0; branch_addr = '0; instr_fetch_started = 1'b0;
        instr_fetch_stopped = 1'b0; instr_data_in = '0; instr_ready = 1'b0; instr_consume = 1'b0;
        m_reset();

        // Fill, drain, mixed lengths and write+pop; outputs sampled before each edge.
        tbl[0]  = mk(1, 0, 16'h0000, 0, 0, 0, 2'd1, 32'h0,        0, 0, 1);
        tbl[1]  = mk(0, 1, 16'h0001, 0, 0, 0, 2'd1, 32'h0,        0, 0, 0);
        tbl[2]  = mk(0, 1, 16'h0002, 0, 1, 1, 2'd1, 32'h00000001, 0, 0, 0);
        tbl[3]  = mk(0, 1, 16'h0003, 0, 2, 1, 2'd1, 32'h00000001, 0, 0, 0);
        tbl[4]  = mk(0, 1, 16'h0004, 0, 3, 1, 2'd1, 32'h00000001, 0, 1, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 4, 1, 2'd1, 32'h00000001, 0, 1, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 4, 1, 2'd1, 32'h00000001, 0, 0, 0);
        tbl[7]  = mk(0, 0, 16'h0000, 1, 3, 1, 2'd1, 32'h00000002, 1, 0, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 2, 1, 2'd2, 32'h00040003, 2, 0, 0);
        tbl[9]  = mk(0, 1, 16'h4501, 0, 0, 0, 2'd1, 32'h0,        4, 0, 0);
        tbl[10] = mk(0, 1, 16'h0013, 0, 1, 1, 2'd1, 32'h00004501, 4, 0, 0);
        tbl[11] = mk(0, 1, 16'h0000, 0, 2, 1, 2'd1, 32'h00004501, 4, 0, 0);
        tbl[12] = mk(0, 0, 16'h0000, 1, 3, 1, 2'd1, 32'h00004501, 4, 0, 0);
        tbl[13] = mk(0, 0, 16'h0000, 1, 2, 1, 2'd2, 32'h00000013, 5, 0, 0);
        tbl[14] = mk(0, 1, 16'h1111, 0, 0, 0, 2'd1, 32'h0,        7, 0, 0);
        tbl[15] = mk(0, 1, 16'h2222, 0, 1, 1, 2'd1, 32'h00001111, 7, 0, 0);
        tbl[16] = mk(0, 1, 16'h3333, 1, 2, 1, 2'd1, 32'h00001111, 7, 0, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 2, 1, 2'd1, 32'h00002222, 8, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_avail", 32'(avail), 32'd0);
        chk("reset_addr", 32'(instr_addr), 32'd0);
        chk("reset_stall", 32'(instr_fetch_stall), 32'd0);
        chk("reset_restart", 32'(instr_fetch_restart), 32'd1);
        rstn = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive_check(1'b0, '0, tbl[i].st, 1'b0, tbl[i].rdy, tbl[i].d, tbl[i].cons);
            chk("tbl_avail", 32'(avail), 32'(tbl[i].e_avail));
            chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].e_valid));
            chk("tbl_pc", 32'(instr_pc), 32'(tbl[i].e_pc));
            chk("tbl_addr", 32'(instr_addr), 32'(tbl[i].e_pc + tbl[i].e_avail));
            chk("tbl_stall", 32'(instr_fetch_stall), 32'(tbl[i].e_stall));
            chk("tbl_restart", 32'(instr_fetch_restart), 32'(tbl[i].e_restart));
            if (tbl[i].e_valid) begin
                chk("tbl_len", 32'(instr_len), 32'(tbl[i].e_len));
                chk("tbl_instr", instr, tbl[i].e_instr);
            end
            advance();
        end

        // Reset asserted mid-stream with three halfwords held.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h4444, 1'b0);
        chk("pre_reset_avail", 32'(avail), 32'd3);
        branch = 1'b0; instr_ready = 1'b0; instr_consume = 1'b0; instr_fetch_started = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_avail", 32'(avail), 32'd0);
        chk("midrst_addr", 32'(instr_addr), 32'd0);
        chk("midrst_restart", 32'(instr_fetch_restart), 32'd1);
        chk("midrst_stall", 32'(instr_fetch_stall), 32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // 32-bit instruction split across the wrap: entry 3 low half, entry 0 upper half.
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h0093, 1'b0);
        drive_check(1'b0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("wrap_half_valid", 32'(instr_valid), 32'd0);
        chk("wrap_half_avail", 32'(avail), 32'd1);
        advance();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0);
        drive_check(1'b0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("wrap_full_valid", 32'(instr_valid), 32'd1);
        chk("wrap_full_instr", instr, 32'h00100093);
        chk("wrap_full_len", 32'(instr_len), 32'd2);
        chk("wrap_full_pc", 32'(instr_pc), 32'd3);
        advance();

        // Branch collides with a write and a pop in the same cycle.
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0);
        drive_check(1'b1, 23'h000100, 1'b0, 1'b0, 1'b1, 16'h0005, 1'b1);
        chk("br_cycle_restart", 32'(instr_fetch_restart), 32'd0);
        advance();
        drive_check(1'b0, '0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("br_avail", 32'(avail), 32'd0);
        chk("br_valid", 32'(instr_valid), 32'd0);
        chk("br_pc", 32'(instr_pc), 32'h100);
        chk("br_addr", 32'(instr_addr), 32'h100);
        chk("br_restart_after", 32'(instr_fetch_restart), 32'd1);
        advance();

        // Randomized traffic; writes are only offered when the queue has room.
        for (int i = 0; i < 400; i++) begin
            logic          r_br, r_st, r_sp, r_rdy, r_cons;
            logic [AB-1:0] r_ba;
            r_br   = ($urandom % 20) == 0;
            r_ba   = AB'($urandom);
            if (($urandom % 4) == 0) r_ba = AB'(AMASK - $urandom_range(0, 3));
            r_st   = ($urandom % 4) == 0;
            r_sp   = ($urandom % 8) == 0;
            r_rdy  = (mq.size() < DEPTH) && ($urandom % 3 != 0);
            r_cons = ($urandom % 2) == 0;
            rd_data = 16'($urandom);
            if ($urandom % 2) rd_data[1:0] = 2'b11;
            step(r_br, r_ba, r_st, r_sp, r_rdy, rd_data, r_cons);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
